// File: rtl/ad_ip_jesd204_tpl_dac_framer_buffered.sv
// rtl/ad_ip_jesd204_tpl_dac_framer_buffered.sv - buffered JESD204 TPL DAC framer
// Beat FIFO in front of a registered sample-to-lane mapper, paced by link_ready.
module ad_ip_jesd204_tpl_dac_framer_buffered #(
    parameter int NUM_LANES            = 8,
    parameter int NUM_CHANNELS         = 4,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int SAMPLES_PER_FRAME    = 2,
    parameter int OCTETS_PER_BEAT      = 4,
    parameter int FIFO_DEPTH           = 4,
    parameter int START_LEVEL          = 2,
    parameter int LINK_DATA_WIDTH      = OCTETS_PER_BEAT * 8 * NUM_LANES,
    parameter int DAC_DATA_WIDTH       = LINK_DATA_WIDTH * CONVERTER_RESOLUTION / BITS_PER_SAMPLE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_CHANNELS-1:0]    channel_enable,
    input  logic                       dfmt_type,
    input  logic                       dac_valid,
    output logic                       dac_ready,
    input  logic [DAC_DATA_WIDTH-1:0]  dac_data,
    input  logic                       link_ready,
    output logic                       link_valid,
    output logic [LINK_DATA_WIDTH-1:0] link_data,
    output logic                       underflow,
    input  logic                       underflow_clr
);
    localparam int W    = LINK_DATA_WIDTH;
    localparam int N    = CONVERTER_RESOLUTION;
    localparam int NP   = BITS_PER_SAMPLE;
    localparam int SAMPLES_PER_BEAT    = DAC_DATA_WIDTH / N;
    localparam int SAMPLES_PER_CHANNEL = SAMPLES_PER_BEAT / NUM_CHANNELS;
    localparam int BITS_PER_CH_FRAME   = NP * SAMPLES_PER_FRAME;
    localparam int BITS_PER_LANE_FRAME = BITS_PER_CH_FRAME * NUM_CHANNELS / NUM_LANES;
    localparam int FRAMES_PER_BEAT     = OCTETS_PER_BEAT * 8 / BITS_PER_LANE_FRAME;
    localparam int TAIL_BITS           = NP - N;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] START_LEVEL_L = LW'(START_LEVEL);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    link_valid_q, link_valid_d;
    logic [W-1:0]            link_data_q, link_data_d;
    logic                    underflow_q, underflow_d;
    logic [DAC_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                      empty, full, run_slot, pop, push;
    logic [DAC_DATA_WIDTH-1:0] fifo_head;
    logic [W-1:0]              msb_s, frame_s, lane_s, mapped_s;

    assign empty     = (level_q == '0);
    assign full      = (level_q == FULL_LEVEL);
    assign run_slot  = (state_q == S_RUN) & enable & link_ready;
    assign pop       = run_slot & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign dac_ready = (state_q != S_IDLE) & (~full | pop);
    assign push      = dac_valid & dac_ready;
    assign fifo_head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dac_data;
        end
    end

    for (genvar i = 0; i < SAMPLES_PER_BEAT; i++) begin : g_sample
        logic [N-1:0] raw;
        logic [N-1:0] fmt;
        assign raw = fifo_head[i*N +: N];
        assign fmt = channel_enable[i / SAMPLES_PER_CHANNEL] ?
                     (raw ^ (N'(dfmt_type) << (N - 1))) : '0;
        assign msb_s[W-1-i*NP -: NP] = NP'(fmt) << TAIL_BITS;
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch_to_frame
        for (genvar j = 0; j < FRAMES_PER_BEAT; j++) begin : g_word
            assign frame_s[(i + j*NUM_CHANNELS)*BITS_PER_CH_FRAME +: BITS_PER_CH_FRAME] =
                   msb_s[(j + i*FRAMES_PER_BEAT)*BITS_PER_CH_FRAME +: BITS_PER_CH_FRAME];
        end
    end

    for (genvar i = 0; i < FRAMES_PER_BEAT; i++) begin : g_frame_to_lane
        for (genvar j = 0; j < NUM_LANES; j++) begin : g_word
            assign lane_s[(i + j*FRAMES_PER_BEAT)*BITS_PER_LANE_FRAME +: BITS_PER_LANE_FRAME] =
                   frame_s[(j + i*NUM_LANES)*BITS_PER_LANE_FRAME +: BITS_PER_LANE_FRAME];
        end
    end

    // First transmitted octet of each lane lands in the lane's low byte.
    for (genvar i = 0; i < W; i += 8) begin : g_octet
        assign mapped_s[i +: 8] = lane_s[W-1-i -: 8];
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q + LW'(push) - LW'(pop);
        link_data_d  = link_data_q;
        underflow_d  = underflow_q & ~underflow_clr;

        case (state_q)
            S_IDLE:  if (enable) state_d = S_FILL;
            S_FILL:  if (level_q >= START_LEVEL_L) state_d = S_RUN;
            default: state_d = state_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (run_slot) begin
            link_data_d = pop ? mapped_s : '0;
            if (empty) underflow_d = 1'b1;
        end

        if (!enable) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end

        link_valid_d = (state_d == S_RUN);
        if (state_d != S_RUN) link_data_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
            underflow_q  <= underflow_d;
        end
    end

    assign link_valid = link_valid_q;
    assign link_data  = link_data_q;
    assign underflow  = underflow_q;

endmodule
